// File: rtl/exp_row_ctrl.sv
// -----------------------------------------------------------------------------
// exp_row_ctrl
//
// Purpose:
//   Front half of a numerically safe softmax for one attention-score row. A
//   single shared combinational exp unit is sequenced across the row in two
//   passes over the row buffer:
//     pass 1 : read every element and track the signed maximum;
//     pass 2 : re-read every element, drive (x - max) into the exp unit, write
//              each exp result back to the same address, and accumulate the
//              row sum for the later normalisation stage.
//   Because x - max is never positive, every exp result is at most 1.0.
//
// Ports:
//   I_CLK       clock, rising edge
//   I_RST       asynchronous active-high reset
//   I_START     start-row pulse, accepted only when idle
//   O_BUSY      high from the cycle after accept through the DONE cycle
//   O_DONE      one-cycle pulse when the row is complete
//   O_RD_EN     row buffer read strobe
//   O_RD_ADDR   row buffer read address
//   I_RD_DATA   signed Q3.13 score, valid exactly one cycle after O_RD_EN
//   O_EXP_X     registered signed Q3.13 operand to the exp unit
//   I_EXP_Y     unsigned Q2.13 exp result, combinational from O_EXP_X
//   O_WR_EN     write-back strobe
//   O_WR_ADDR   write-back address
//   O_WR_DATA   exp result written back (zero when O_WR_EN is low)
//   O_MAX       row maximum, held after DONE
//   O_SUM       sum of all written exp results, held after DONE
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module exp_row_ctrl #(
  parameter int D_W     = 16,
  parameter int ROW_LEN = 16,
  parameter int ADDR_W  = $clog2(ROW_LEN),
  parameter int SUM_W   = D_W + ADDR_W
) (
  input  logic              I_CLK,
  input  logic              I_RST,
  input  logic              I_START,
  output logic              O_BUSY,
  output logic              O_DONE,
  output logic              O_RD_EN,
  output logic [ADDR_W-1:0] O_RD_ADDR,
  input  logic [D_W-1:0]    I_RD_DATA,
  output logic [D_W-1:0]    O_EXP_X,
  input  logic [D_W-1:0]    I_EXP_Y,
  output logic              O_WR_EN,
  output logic [ADDR_W-1:0] O_WR_ADDR,
  output logic [D_W-1:0]    O_WR_DATA,
  output logic [D_W-1:0]    O_MAX,
  output logic [SUM_W-1:0]  O_SUM
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_MAX_RD,
    S_MAX_DRAIN,
    S_EXP_RD,
    S_EXP_DRAIN1,
    S_EXP_DRAIN2,
    S_DONE
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(ROW_LEN - 1);
  localparam logic [D_W-1:0]    MOST_NEG  = {1'b1, {(D_W-1){1'b0}}};

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  state_t              state_q,   state_d;
  logic [ADDR_W-1:0]   cnt_q,     cnt_d;      // read address within a pass
  logic                rd_vld_q,  rd_vld_d;   // I_RD_DATA valid this cycle
  logic                rd_p2_q,   rd_p2_d;    // ... and it belongs to pass 2
  logic                first_q,   first_d;    // next pass-1 element is element 0
  logic [D_W-1:0]      max_q,     max_d;
  logic [D_W-1:0]      exp_x_q,   exp_x_d;
  logic                exp_vld_q, exp_vld_d;  // O_EXP_X holds a fresh element
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [SUM_W-1:0]    sum_q,     sum_d;

  logic                start_acc;
  logic                rd_en;
  logic signed [D_W:0] diff;
  logic [D_W-1:0]      diff_sat;

  assign start_acc = (state_q == S_IDLE) && I_START;
  assign rd_en     = (state_q == S_MAX_RD) || (state_q == S_EXP_RD);

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every signal assigned in an always_comb gets a default at the top;
  // a path that leaves one unassigned would infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (I_START) begin
          state_d = S_MAX_RD;
          cnt_d   = '0;
        end
      end
      S_MAX_RD: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_ADDR) begin
          state_d = S_MAX_DRAIN;
          cnt_d   = '0;
        end
      end
      S_MAX_DRAIN:  state_d = S_EXP_RD;
      S_EXP_RD: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_ADDR) begin
          state_d = S_EXP_DRAIN1;
          cnt_d   = '0;
        end
      end
      S_EXP_DRAIN1: state_d = S_EXP_DRAIN2;
      S_EXP_DRAIN2: state_d = S_DONE;
      S_DONE:       state_d = S_IDLE;
      default:      state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath next values
  // ---------------------------------------------------------------------------
  // diff is formed one bit wider so that (most negative - most positive) is
  // representable before clamping; it can never be positive because max is
  // taken over the same row.
  always_comb begin
    diff = $signed({I_RD_DATA[D_W-1], I_RD_DATA}) - $signed({max_q[D_W-1], max_q});
    if (diff[D_W] && !diff[D_W-1]) begin
      diff_sat = MOST_NEG;
    end else begin
      diff_sat = diff[D_W-1:0];
    end
  end

  always_comb begin
    rd_vld_d  = rd_en;
    rd_p2_d   = (state_q == S_EXP_RD);
    first_d   = first_q;
    max_d     = max_q;
    exp_x_d   = exp_x_q;
    exp_vld_d = rd_vld_q && rd_p2_q;
    wr_addr_d = wr_addr_q;
    sum_d     = sum_q;

    if (start_acc) begin
      first_d   = 1'b1;
      wr_addr_d = '0;
      sum_d     = '0;
    end

    // Pass 1: ties keep the current value; element 0 always overwrites the
    // maximum left over from the previous row.
    if (rd_vld_q && !rd_p2_q) begin
      first_d = 1'b0;
      if (first_q || ($signed(I_RD_DATA) > $signed(max_q))) begin
        max_d = I_RD_DATA;
      end
    end

    // Pass 2, subtract stage.
    if (rd_vld_q && rd_p2_q) begin
      exp_x_d = diff_sat;
    end

    // Pass 2, write stage: I_EXP_Y belongs to the element now in O_EXP_X.
    if (exp_vld_q) begin
      wr_addr_d = wr_addr_q + 1'b1;
      sum_d     = sum_q + SUM_W'(I_EXP_Y);
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the values from before the edge regardless of order.
  always_ff @(posedge I_CLK or posedge I_RST) begin
    if (I_RST) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      rd_vld_q  <= 1'b0;
      rd_p2_q   <= 1'b0;
      first_q   <= 1'b0;
      max_q     <= '0;
      exp_x_q   <= '0;
      exp_vld_q <= 1'b0;
      wr_addr_q <= '0;
      sum_q     <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rd_vld_q  <= rd_vld_d;
      rd_p2_q   <= rd_p2_d;
      first_q   <= first_d;
      max_q     <= max_d;
      exp_x_q   <= exp_x_d;
      exp_vld_q <= exp_vld_d;
      wr_addr_q <= wr_addr_d;
      sum_q     <= sum_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  // Addresses and write data are gated so the bus is quiet when not strobed.
  assign O_BUSY    = (state_q != S_IDLE);
  assign O_DONE    = (state_q == S_DONE);
  assign O_RD_EN   = rd_en;
  assign O_RD_ADDR = rd_en ? cnt_q : '0;
  assign O_EXP_X   = exp_x_q;
  assign O_WR_EN   = exp_vld_q;
  assign O_WR_ADDR = exp_vld_q ? wr_addr_q : '0;
  assign O_WR_DATA = exp_vld_q ? I_EXP_Y : '0;
  assign O_MAX     = max_q;
  assign O_SUM     = sum_q;

endmodule

// File: tb/tb_exp_row_ctrl.sv
// -----------------------------------------------------------------------------
// tb_exp_row_ctrl
//
// Purpose:
//   Self-checking bench for exp_row_ctrl with ROW_LEN = 4. Provides a row
//   buffer with one-cycle read latency and a real-valued exp unit, checks the
//   cycle-by-cycle schedule against the published timetable, and checks max,
//   exp operands, write data and sum against a reference computed directly
//   from the row values.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_exp_row_ctrl;

  localparam int N  = 4;
  localparam int DW = 16;
  localparam int AW = 2;
  localparam int SW = DW + AW;

  logic          I_CLK;
  logic          I_RST;
  logic          I_START;
  logic          O_BUSY;
  logic          O_DONE;
  logic          O_RD_EN;
  logic [AW-1:0] O_RD_ADDR;
  logic [DW-1:0] I_RD_DATA;
  logic [DW-1:0] O_EXP_X;
  logic [DW-1:0] I_EXP_Y;
  logic          O_WR_EN;
  logic [AW-1:0] O_WR_ADDR;
  logic [DW-1:0] O_WR_DATA;
  logic [DW-1:0] O_MAX;
  logic [SW-1:0] O_SUM;

  exp_row_ctrl #(.D_W(DW), .ROW_LEN(N)) dut (
    .I_CLK     (I_CLK),
    .I_RST     (I_RST),
    .I_START   (I_START),
    .O_BUSY    (O_BUSY),
    .O_DONE    (O_DONE),
    .O_RD_EN   (O_RD_EN),
    .O_RD_ADDR (O_RD_ADDR),
    .I_RD_DATA (I_RD_DATA),
    .O_EXP_X   (O_EXP_X),
    .I_EXP_Y   (I_EXP_Y),
    .O_WR_EN   (O_WR_EN),
    .O_WR_ADDR (O_WR_ADDR),
    .O_WR_DATA (O_WR_DATA),
    .O_MAX     (O_MAX),
    .O_SUM     (O_SUM)
  );

  initial I_CLK = 1'b0;
  always #5 I_CLK = ~I_CLK;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Environment models
  // ---------------------------------------------------------------------------
  // exp(x) for Q3.13 signed x, returned as Q2.13 rounded to nearest.
  function automatic logic [DW-1:0] exp_fn(input logic [DW-1:0] x);
    real r;
    r = $exp(real'($signed(x)) / 8192.0) * 8192.0;
    return DW'($rtoi(r + 0.5));
  endfunction

  always_comb I_EXP_Y = exp_fn(O_EXP_X);

  // Row buffer: data valid one cycle after the strobe, junk otherwise.
  logic [DW-1:0] row_mem [N];
  always @(posedge I_CLK) begin
    if (O_RD_EN) I_RD_DATA <= row_mem[O_RD_ADDR];
    else         I_RD_DATA <= DW'($urandom);
  end

  typedef logic [N-1:0][DW-1:0] row_t;

  function automatic row_t mk(input int a0, input int a1, input int a2, input int a3);
    row_t r;
    r[0] = DW'(a0); r[1] = DW'(a1); r[2] = DW'(a2); r[3] = DW'(a3);
    return r;
  endfunction

  // Reference: max over the row, then saturated differences.
  function automatic logic [DW-1:0] ref_max(input row_t r);
    int m;
    m = $signed(r[0]);
    for (int i = 1; i < N; i++) if ($signed(r[i]) > m) m = $signed(r[i]);
    return DW'(m);
  endfunction

  function automatic row_t ref_diffs(input row_t r);
    row_t d;
    int   m, v;
    m = $signed(ref_max(r));
    for (int i = 0; i < N; i++) begin
      v = $signed(r[i]) - m;
      if (v < -32768) v = -32768;
      d[i] = DW'(v);
    end
    return d;
  endfunction

  // ---------------------------------------------------------------------------
  // One row from IDLE, checked against the timetable. Must be entered on a
  // falling edge with the DUT idle.
  // ---------------------------------------------------------------------------
  task automatic run_row(input string tag, input row_t row, input logic [DW-1:0] emax,
                         input row_t ex, input bit extra_starts);
    int  done_cnt;
    int  sum;
    bit  e_rd, e_wr;
    for (int i = 0; i < N; i++) row_mem[i] = row[i];
    done_cnt = 0;
    sum      = 0;
    I_START  = 1'b1;                     // cycle 0
    @(negedge I_CLK);
    I_START  = 1'b0;
    for (int c = 1; c <= 2*N+5; c++) begin
      e_rd = (c >= 1 && c <= N) || (c >= N+2 && c <= 2*N+1);
      e_wr = (c >= N+4 && c <= 2*N+3);
      check($sformatf("%s ctl c%0d", tag, c), {O_BUSY, O_DONE, O_RD_EN, O_WR_EN},
            {(c <= 2*N+4), (c == 2*N+4), e_rd, e_wr});
      if (e_rd)
        check($sformatf("%s rd_addr c%0d", tag, c), O_RD_ADDR,
              (c <= N) ? c-1 : c-N-2);
      if (e_wr) begin
        check($sformatf("%s wr_addr c%0d", tag, c), O_WR_ADDR, c-N-4);
        check($sformatf("%s exp_x c%0d", tag, c), O_EXP_X, ex[c-N-4]);
        check($sformatf("%s wr_data c%0d", tag, c), O_WR_DATA, exp_fn(ex[c-N-4]));
        sum += int'(exp_fn(ex[c-N-4]));
      end else begin
        check($sformatf("%s wr_data idle c%0d", tag, c), O_WR_DATA, 0);
      end
      if (O_DONE) done_cnt++;
      I_START = extra_starts && (c == 3 || c == 2*N+4);
      @(negedge I_CLK);
    end
    I_START = 1'b0;
    check({tag, " done count"}, done_cnt, 1);
    check({tag, " max"}, O_MAX, emax);
    check({tag, " sum"}, O_SUM, sum);
  endtask

  typedef struct {
    string         name;
    row_t          row;
    logic [DW-1:0] emax;
    row_t          ex;
  } vec_t;

  vec_t vecs [6];

  initial begin
    row_t r;

    vecs[0] = '{"zeros",  mk(0, 0, 0, 0),                16'd0,     mk(0, 0, 0, 0)};
    vecs[1] = '{"mixed",  mk(-8192, 4096, 16384, -1),    16'd16384, mk(-24576, -12288, 0, -16385)};
    vecs[2] = '{"sat",    mk(-32768, 32767, 0, 32767),   16'd32767, mk(-32768, 0, -32767, 0)};
    vecs[3] = '{"tie",    mk(5, 5, 5, 5),                16'd5,     mk(0, 0, 0, 0)};
    vecs[4] = '{"first",  mk(7, -3, -3, -3),             16'd7,     mk(0, -10, -10, -10)};
    vecs[5] = '{"allneg", mk(-100, -50, -200, -50),      -16'sd50,  mk(-50, 0, -150, 0)};

    I_START = 1'b0;
    I_RST   = 1'b1;
    for (int i = 0; i < N; i++) row_mem[i] = '0;
    repeat (2) @(negedge I_CLK);
    check("reset outputs",
          {O_BUSY, O_DONE, O_RD_EN, O_RD_ADDR, O_EXP_X, O_WR_EN, O_WR_ADDR, O_WR_DATA},
          '0);
    check("reset max/sum", {O_MAX, O_SUM}, '0);
    I_RST = 1'b0;
    @(negedge I_CLK);

    // Directed table.
    for (int v = 0; v < 6; v++)
      run_row(vecs[v].name, vecs[v].row, vecs[v].emax, vecs[v].ex, 1'b0);

    // Starts during a run (cycle 3 and the DONE cycle) are ignored.
    run_row("busy_start", vecs[1].row, vecs[1].emax, vecs[1].ex, 1'b1);

    // Asynchronous reset in the middle of the write-back pass.
    for (int i = 0; i < N; i++) row_mem[i] = vecs[1].row[i];
    I_START = 1'b1;
    @(negedge I_CLK);
    I_START = 1'b0;
    repeat (2*N) @(negedge I_CLK);       // now in cycle 2N+1, still EXP_RD
    check("pre-reset busy/wr", {O_BUSY, O_WR_EN}, 2'b11);
    #2 I_RST = 1'b1;
    #1;
    check("midrow reset outputs",
          {O_BUSY, O_DONE, O_RD_EN, O_RD_ADDR, O_EXP_X, O_WR_EN, O_WR_ADDR, O_WR_DATA},
          '0);
    check("midrow reset max/sum", {O_MAX, O_SUM}, '0);
    @(negedge I_CLK);
    I_RST = 1'b0;
    @(negedge I_CLK);
    run_row("after_reset", vecs[2].row, vecs[2].emax, vecs[2].ex, 1'b0);

    // Randomised rows against the reference, with extremes mixed in.
    for (int k = 0; k < 12; k++) begin
      for (int i = 0; i < N; i++) begin
        case ($urandom_range(0, 4))
          0:       r[i] = 16'h8000;
          1:       r[i] = 16'h7FFF;
          default: r[i] = DW'($urandom);
        endcase
      end
      run_row($sformatf("rand%0d", k), r, ref_max(r), ref_diffs(r), k[0]);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global time bound in case the DUT or bench ever stalls.
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
